// File: rtl/wb_commit_pkg.sv
// wb_commit_pkg: exception codes, op encodings, CP0 addresses, handler entry and WB register layout
package wb_commit_pkg;
  localparam logic [31:0] EX_ENTRY     = 32'hbfc00380;
  localparam logic [4:0]  EXC_INT      = 5'd0;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam logic [4:0]  EXC_ADES     = 5'd5;
  localparam logic [4:0]  EXC_SYS      = 5'd8;
  localparam logic [4:0]  EXC_BP       = 5'd9;
  localparam logic [4:0]  EXC_RI       = 5'd10;
  localparam logic [4:0]  EXC_OV       = 5'd12;
  localparam logic [7:0]  CP0_BADVADDR = {5'd8, 3'd0};
  localparam logic [7:0]  CP0_COUNT    = {5'd9, 3'd0};
  localparam logic [7:0]  CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0]  CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0]  CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0]  CP0_EPC      = {5'd14, 3'd0};
  typedef enum logic [2:0] {
    OP_NORMAL = 3'd0,
    OP_MTC0   = 3'd1,
    OP_MFC0   = 3'd2,
    OP_ERET   = 3'd3
  } op_e;
  typedef struct packed {
    logic [31:0] pc;
    logic        ex;
    logic [4:0]  exccode;
    logic        bd;
    logic [31:0] badvaddr;
    op_e         op;
    logic [7:0]  cp0_addr;
    logic        gpr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } ws_t;
endpackage

// File: rtl/wb_commit_if.sv
// wb_commit_if: MEM->WB handshake bundle (valid/allowin plus instruction fields); master=MEM, slave=WB
interface wb_commit_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_ex;
  logic [4:0]  ms_exccode;
  logic        ms_bd;
  logic [31:0] ms_badvaddr;
  logic [2:0]  ms_op;
  logic [7:0]  ms_cp0_addr;
  logic        ms_gpr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  modport master (
    output ms_to_ws_valid, ms_pc, ms_ex, ms_exccode, ms_bd, ms_badvaddr,
           ms_op, ms_cp0_addr, ms_gpr_we, ms_dest, ms_result,
    input  ws_allowin
  );
  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_ex, ms_exccode, ms_bd, ms_badvaddr,
           ms_op, ms_cp0_addr, ms_gpr_we, ms_dest, ms_result,
    output ws_allowin
  );
endinterface

// File: rtl/wb_commit.sv
// wb_commit: WB register + commit/exception/eret decision; ports clk/rst, ms (MEM handshake), CP0 read/write/exception port, GPR write, flush/redirect
module wb_commit
  import wb_commit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  wb_commit_if.slave  ms,
  input  logic        has_int,
  input  logic [31:0] cp0_rdata,
  input  logic [31:0] cp0_epc,
  output logic        mtc0_we,
  output logic [31:0] cp0_wdata,
  output logic [7:0]  cp0_addr,
  output logic        wb_ex,
  output logic [4:0]  wb_exccode,
  output logic        wb_bd,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_BadVaddr,
  output logic        eret_flush,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic [31:0] flush_pc
);
  logic ws_valid_q, ws_valid_d, load;
  ws_t  ws_q, ws_d;
  always_comb begin
    ms.ws_allowin = 1'b1;
    wb_ex         = ws_valid_q && (has_int || ws_q.ex);
    wb_exccode    = has_int ? EXC_INT : ws_q.exccode;
    wb_bd         = ws_q.bd;
    wb_pc         = ws_q.pc;
    wb_BadVaddr   = ws_q.badvaddr;
    eret_flush    = ws_valid_q && ws_q.op == OP_ERET && !wb_ex;
    mtc0_we       = ws_valid_q && ws_q.op == OP_MTC0 && !wb_ex;
    cp0_wdata     = ws_q.result;
    cp0_addr      = ws_q.cp0_addr;
    rf_we         = ws_valid_q && !wb_ex &&
                    (ws_q.op == OP_MFC0 || (ws_q.op == OP_NORMAL && ws_q.gpr_we));
    rf_waddr      = ws_q.dest;
    rf_wdata      = ws_q.op == OP_MFC0 ? cp0_rdata : ws_q.result;
    flush         = wb_ex || eret_flush;
    flush_pc      = eret_flush ? cp0_epc : EX_ENTRY;
    load          = ms.ws_allowin && ms.ms_to_ws_valid && !flush;
    ws_valid_d    = load;
    ws_d          = load ? '{pc: ms.ms_pc, ex: ms.ms_ex, exccode: ms.ms_exccode,
                             bd: ms.ms_bd, badvaddr: ms.ms_badvaddr, op: op_e'(ms.ms_op),
                             cp0_addr: ms.ms_cp0_addr, gpr_we: ms.ms_gpr_we,
                             dest: ms.ms_dest, result: ms.ms_result}
                         : ws_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_valid_q <= 1'b0;
      ws_q       <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      ws_q       <= ws_d;
    end
  end
endmodule
